// File: rtl/counter_time_gen_if.sv
// Bundles the control and status signals of counter_time_gen.
// The warn signal exists only when COUNTER_TIME_WARN_EN is defined.
interface counter_time_gen_if #(
  parameter int W = 4
);
  logic         E;
  logic         LOAD;
  logic         DOWN;
  logic [W-1:0] LIMIT;
  logic [W-1:0] TEMPO;
  logic         tick;
  logic         end_time;
`ifdef COUNTER_TIME_WARN_EN
  logic         warn;

  modport master (
    output E, LOAD, DOWN, LIMIT,
    input  TEMPO, tick, end_time, warn
  );

  modport slave (
    input  E, LOAD, DOWN, LIMIT,
    output TEMPO, tick, end_time, warn
  );
`else
  modport master (
    output E, LOAD, DOWN, LIMIT,
    input  TEMPO, tick, end_time
  );

  modport slave (
    input  E, LOAD, DOWN, LIMIT,
    output TEMPO, tick, end_time
  );
`endif
endinterface

// File: rtl/counter_time_gen.sv
// Round timer: prescales CLOCK_50 and counts TEMPO up to or down from a loaded limit.
// Optional warn output near the terminal value is enabled by COUNTER_TIME_WARN_EN.
module counter_time_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int W         = 4,
  parameter int WARN_LEFT = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    R,
  counter_time_gen_if.slave       bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  if (DIV < 1 || WARN_LEFT < 0) begin : g_bad_param
    $error("counter_time_gen: DIV must be >= 1 and WARN_LEFT >= 0");
  end

  logic [PW-1:0] pre;
  logic [W-1:0]  lim_r;
  logic          mode_r;
  logic [W-1:0]  tempo_r;
  logic          tick_r;
  logic          end_r;

  logic [W-1:0]  term;
  logic [W-1:0]  next_tempo;

  always_comb begin
    term       = mode_r ? '0 : lim_r;
    next_tempo = mode_r ? (tempo_r - W'(1)) : (tempo_r + W'(1));
  end

  // Terminal check happens before the step so TEMPO can never wrap.
  always_ff @(posedge CLOCK_50 or negedge R) begin
    if (!R) begin
      pre     <= '0;
      lim_r   <= '1;
      mode_r  <= 1'b0;
      tempo_r <= '0;
      tick_r  <= 1'b0;
      end_r   <= 1'b0;
    end else if (bus.LOAD) begin
      lim_r   <= bus.LIMIT;
      mode_r  <= bus.DOWN;
      pre     <= '0;
      tick_r  <= 1'b0;
      tempo_r <= bus.DOWN ? bus.LIMIT : '0;
      end_r   <= (bus.LIMIT == '0);
    end else if (bus.E && !end_r) begin
      if (tempo_r == term) begin
        pre    <= '0;
        tick_r <= 1'b0;
        end_r  <= 1'b1;
      end else if (pre == PRE_MAX) begin
        pre     <= '0;
        tempo_r <= next_tempo;
        tick_r  <= 1'b1;
        end_r   <= (next_tempo == term);
      end else begin
        pre    <= pre + PW'(1);
        tick_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign bus.TEMPO    = tempo_r;
  assign bus.tick     = tick_r;
  assign bus.end_time = end_r;

`ifdef COUNTER_TIME_WARN_EN
  logic [W-1:0] remaining;

  always_comb begin
    remaining = mode_r ? tempo_r : (lim_r - tempo_r);
  end

  assign bus.warn = !end_r && (32'(remaining) <= $unsigned(WARN_LEFT));
`endif

endmodule

// File: tb/tb_counter_time_gen.sv
// Directed self-checking bench for counter_time_gen with DIV=4, W=4.
// Define COUNTER_TIME_WARN_EN to also exercise the warn output.
module tb_counter_time_gen;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  counter_time_gen_if #(.W(W)) bus_if ();

  counter_time_gen #(
    .CLK_HZ(4),
    .TICK_HZ(1),
    .W(W),
    .WARN_LEFT(3)
  ) dut (
    .CLOCK_50(clk),
    .R(rst_n),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         e;
    logic         load;
    logic         down;
    logic [W-1:0] limit;
    int           cycles;
    logic [W-1:0] exp_tempo;
    logic         exp_tick;
    logic         exp_end;
    string        name;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(logic e, logic load, logic down, logic [W-1:0] limit,
                              int cycles, logic [W-1:0] t, logic tk, logic en, string name);
    vec_t v;
    v.e = e; v.load = load; v.down = down; v.limit = limit; v.cycles = cycles;
    v.exp_tempo = t; v.exp_tick = tk; v.exp_end = en; v.name = name;
    return v;
  endfunction

  task automatic apply_stimulus(logic e, logic load, logic down, logic [W-1:0] limit);
    bus_if.E     = e;
    bus_if.LOAD  = load;
    bus_if.DOWN  = down;
    bus_if.LIMIT = limit;
  endtask

  task automatic cycle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(string name, logic [W-1:0] t, logic tk, logic en);
    checks++;
    if (bus_if.TEMPO !== t || bus_if.tick !== tk || bus_if.end_time !== en) begin
      failures++;
      $display("[TB] FAIL %s: got TEMPO=%0d tick=%0b end_time=%0b, expected TEMPO=%0d tick=%0b end_time=%0b",
               name, bus_if.TEMPO, bus_if.tick, bus_if.end_time, t, tk, en);
    end
  endtask

  task automatic check_value(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected state k enabled edges after a restart from 0, counting up with DIV=4.
  task automatic check_up_edge(string name, int k, int lim);
    int exp_t;
    exp_t = (k / 4 > lim) ? lim : k / 4;
    check_output(name, W'(exp_t), (k % 4 == 0) && (k > 0) && (k <= 4 * lim), k >= 4 * lim);
  endtask

  vec_t vecs[$];
  int   tick_count;
  int   end_edge;

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    #12;
    check_output("reset_state", 4'd0, 1'b0, 1'b0);
`ifdef COUNTER_TIME_WARN_EN
    check_value("warn_reset", int'(bus_if.warn), 0);
`endif

    // Legacy default: count up to 15 with no LOAD.
    @(negedge clk);
    rst_n  = 1'b1;
    bus_if.E = 1'b1;
    tick_count = 0;
    end_edge   = -1;
    for (int k = 1; k <= 72; k++) begin
      @(posedge clk); #1;
      check_up_edge("legacy_edge", k, 15);
      if (bus_if.tick) tick_count++;
      if (bus_if.end_time && end_edge < 0) end_edge = k;
    end
    check_value("legacy_tick_total", tick_count, 15);
    check_value("legacy_end_edge", end_edge, 60);

    // Table: down count, ignored inputs, LOAD collisions, zero limit, pause.
    vecs.push_back(mk(1, 1, 1, 4'd5, 1, 4'd5, 0, 0, "down_load"));
    vecs.push_back(mk(1, 0, 1, 4'd5, 3, 4'd5, 0, 0, "down_pre3"));
    vecs.push_back(mk(1, 0, 1, 4'd5, 1, 4'd4, 1, 0, "down_step4"));
    vecs.push_back(mk(1, 0, 1, 4'd5, 4, 4'd3, 1, 0, "down_step3"));
    vecs.push_back(mk(1, 0, 1, 4'd5, 4, 4'd2, 1, 0, "down_step2"));
    vecs.push_back(mk(1, 0, 1, 4'd5, 4, 4'd1, 1, 0, "down_step1"));
    vecs.push_back(mk(1, 0, 1, 4'd5, 4, 4'd0, 1, 1, "down_end_edge20"));
    vecs.push_back(mk(1, 0, 1, 4'd5, 3, 4'd0, 0, 1, "down_hold"));
    vecs.push_back(mk(1, 0, 0, 4'd9, 4, 4'd0, 0, 1, "no_load_ignored"));
    vecs.push_back(mk(1, 1, 0, 4'd9, 1, 4'd0, 0, 0, "reload_clears_end"));
    vecs.push_back(mk(1, 0, 0, 4'd9, 4, 4'd1, 1, 0, "up_first_step"));
    vecs.push_back(mk(1, 0, 0, 4'd9, 3, 4'd1, 0, 0, "up_pre3"));
    vecs.push_back(mk(1, 1, 0, 4'd9, 1, 4'd0, 0, 0, "load_on_wrap"));
    vecs.push_back(mk(1, 0, 0, 4'd9, 3, 4'd0, 0, 0, "after_collision"));
    vecs.push_back(mk(1, 0, 0, 4'd9, 1, 4'd1, 1, 0, "collision_restart"));
    vecs.push_back(mk(1, 1, 0, 4'd0, 1, 4'd0, 0, 1, "zero_limit_load"));
    vecs.push_back(mk(1, 0, 0, 4'd0, 8, 4'd0, 0, 1, "zero_limit_hold"));
    vecs.push_back(mk(0, 1, 1, 4'd2, 1, 4'd2, 0, 0, "down_load_e0"));
    vecs.push_back(mk(0, 0, 1, 4'd2, 5, 4'd2, 0, 0, "e0_hold"));
    vecs.push_back(mk(1, 0, 1, 4'd2, 4, 4'd1, 1, 0, "down2_step1"));
    vecs.push_back(mk(1, 0, 1, 4'd2, 4, 4'd0, 1, 1, "down2_end"));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].e, vecs[i].load, vecs[i].down, vecs[i].limit);
      cycle(vecs[i].cycles);
      check_output(vecs[i].name, vecs[i].exp_tempo, vecs[i].exp_tick, vecs[i].exp_end);
    end

    // Pause at pre=2 for 7 edges delays the first step to edge 11.
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'd9);
    cycle(1);
    check_output("pause_load", 4'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd9);
    cycle(2);
    bus_if.E = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycle(1);
      check_output("pause_hold", 4'd0, 1'b0, 1'b0);
    end
    bus_if.E = 1'b1;
    cycle(1);
    check_output("pause_resume_pre3", 4'd0, 1'b0, 1'b0);
    cycle(1);
    check_output("pause_step_edge11", 4'd1, 1'b1, 1'b0);

    // Async reset mid-count at TEMPO=7.
    rst_n = 1'b0;
    #1;
    check_output("reset_assert", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(28);
    check_output("reach_tempo7", 4'd7, 1'b1, 1'b0);
    cycle(1);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_no_clock", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      check_up_edge("post_reset_edge", k, 15);
    end

`ifdef COUNTER_TIME_WARN_EN
    // warn rises at TEMPO=3 and drops when end_time sets at TEMPO=6.
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'd6);
    cycle(1);
    check_value("warn_after_load", int'(bus_if.warn), 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'd6);
    for (int k = 1; k <= 28; k++) begin
      int exp_t;
      @(posedge clk); #1;
      check_up_edge("warn_run_edge", k, 6);
      exp_t = (k / 4 > 6) ? 6 : k / 4;
      check_value("warn_level", int'(bus_if.warn), ((k < 24) && (exp_t >= 3)) ? 1 : 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
